// File: rtl/ultrasonido_filtro.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonido_filtro
// Description : Measurement sequencer and moving-average filter for an
//               ultrasonic ranging module. Pulses ENABLE once per
//               PERIOD_CYC clocks and captures the distance on each rising
//               edge of DONE. It averages the last 2^N_LOG2 samples and raises
//               a hysteretic "near" flag. A measurement that gets no DONE
//               within TIMEOUT_CYC clocks is reported through timeout_err.
// Ports       :
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset, clears all state
//   run         in   level, keep measuring periodically while high
//   d[7:0]      in   distance (cm) from the ranging module, valid on DONE rise
//   DONE        in   measurement-complete level from the ranging module
//   ENABLE      out  start/hold request to the ranging module
//   dist_avg    out  filtered distance (cm)
//   valid       out  one-cycle pulse when dist_avg updates
//   near        out  obstacle-near flag with hysteresis
//   timeout_err out  last measurement received no DONE
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonido_filtro #(
  parameter int PERIOD_CYC  = 3000000,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int N_LOG2      = 2,
  parameter int TH_NEAR     = 20,
  parameter int TH_FAR      = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] d,
  input  logic       DONE,
  output logic       ENABLE,
  output logic [7:0] dist_avg,
  output logic       valid,
  output logic       near,
  output logic       timeout_err
);

  localparam int DEPTH  = 1 << N_LOG2;
  localparam int SUM_W  = 8 + N_LOG2;
  localparam int FILL_W = N_LOG2 + 1;
  localparam int PER_W  = $clog2(PERIOD_CYC);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q;
  logic               enable_q;
  logic               done_q;
  logic               timeout_q;
  logic [PER_W-1:0]   per_q;
  logic [TMO_W-1:0]   tmo_q;

  logic [7:0]         buf_q [DEPTH];
  logic [N_LOG2-1:0]  wp_q;
  logic [SUM_W-1:0]   sum_q;
  logic [FILL_W-1:0]  fill_q;
  logic               upd_q;
  logic [7:0]         avg_q;
  logic               valid_q;
  logic               near_q;

  logic               done_rise;
  logic               accept;
  logic               tmo_term;
  logic               per_term;
  logic [7:0]         avg_new;

  assign done_rise = DONE & ~done_q;
  assign accept    = (state_q == S_WAIT) && done_rise;
  assign tmo_term  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign per_term  = (per_q == PER_W'(PERIOD_CYC - 1));
  // Truncating divide by the window size.
  assign avg_new   = sum_q[SUM_W-1:N_LOG2];

  // --------------------------------------------------------------------------
  // Sequencer. Both counters are zero in the START cycle and count every
  // clock after it, so START cycles are exactly PERIOD_CYC apart and the
  // timeout fires TIMEOUT_CYC clocks after ENABLE rises. ENABLE is set on the
  // transition into START so it is already high during the START cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      per_q     <= '0;
      tmo_q     <= '0;
    end else begin
      done_q <= DONE;
      case (state_q)
        S_IDLE: begin
          enable_q <= 1'b0;
          if (run) begin
            state_q  <= S_START;
            enable_q <= 1'b1;
            per_q    <= '0;
            tmo_q    <= '0;
          end
        end
        S_START: begin
          per_q   <= per_q + 1'b1;
          tmo_q   <= tmo_q + 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          per_q <= per_q + 1'b1;
          tmo_q <= tmo_q + 1'b1;
          // An edge on the terminal cycle still counts as a good sample.
          if (done_rise) begin
            state_q   <= S_GAP;
            enable_q  <= 1'b0;
            timeout_q <= 1'b0;
          end else if (tmo_term) begin
            state_q   <= S_GAP;
            enable_q  <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (per_term) begin
            per_q <= '0;
            tmo_q <= '0;
            if (run) begin
              state_q  <= S_START;
              enable_q <= 1'b1;
            end else begin
              state_q  <= S_IDLE;
            end
          end else begin
            per_q <= per_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Moving-average filter. The running sum is updated at the edge that ends
  // the capture cycle, and the average is published one edge later. Samples
  // taken before the window first fills update the history silently.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wp_q    <= '0;
      sum_q   <= '0;
      fill_q  <= '0;
      upd_q   <= 1'b0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      near_q  <= 1'b0;
    end else begin
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      if (accept) begin
        buf_q[wp_q] <= d;
        // Intermediate wrap is harmless: the final sum always fits.
        sum_q       <= sum_q - SUM_W'(buf_q[wp_q]) + SUM_W'(d);
        wp_q        <= wp_q + 1'b1;
        if (fill_q != FILL_W'(DEPTH)) begin
          fill_q <= fill_q + 1'b1;
        end
        upd_q <= (fill_q >= FILL_W'(DEPTH - 1));
      end
      if (upd_q) begin
        avg_q   <= avg_new;
        valid_q <= 1'b1;
        if (avg_new < 8'(TH_NEAR)) begin
          near_q <= 1'b1;
        end else if (avg_new > 8'(TH_FAR)) begin
          near_q <= 1'b0;
        end
      end
    end
  end

  assign ENABLE      = enable_q;
  assign dist_avg    = avg_q;
  assign valid       = valid_q;
  assign near        = near_q;
  assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonido_filtro.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonido_filtro
// Description : Self-checking bench for ultrasonido_filtro. A simple ranging
//               model answers each ENABLE, and a queue-based reference model
//               predicts the filter outputs. It applies a fixed vector table,
//               targeted corner sequences and randomized measurements.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonido_filtro;

  localparam int PERIOD = 1000;
  localparam int TMO    = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       DONE;
  logic [7:0] d;
  logic       ENABLE;
  logic [7:0] dist_avg;
  logic       valid;
  logic       near;
  logic       timeout_err;

  always #5 clk = ~clk;

  ultrasonido_filtro #(
    .PERIOD_CYC (PERIOD),
    .TIMEOUT_CYC(TMO),
    .N_LOG2     (2),
    .TH_NEAR    (20),
    .TH_FAR     (25)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .d          (d),
    .DONE       (DONE),
    .ENABLE     (ENABLE),
    .dist_avg   (dist_avg),
    .valid      (valid),
    .near       (near),
    .timeout_err(timeout_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rise_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the last four accepted samples and the near flag.
  int hist[$];
  int n_acc;
  bit m_near;

  typedef struct {
    int d;
    bit v;
    int avg;
    bit nr;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    n_acc  = 0;
    m_near = 0;
  endtask

  task automatic model_push(input int dv, output bit ev, output int eavg, output bit enear);
    int s;
    hist.push_back(dv);
    if (hist.size() > 4) void'(hist.pop_front());
    n_acc++;
    ev   = (n_acc >= 4);
    eavg = 0;
    if (ev) begin
      s = 0;
      foreach (hist[i]) s += hist[i];
      eavg = s / 4;
      if (eavg < 20) m_near = 1;
      else if (eavg > 25) m_near = 0;
    end
    enear = m_near;
  endtask

  // Returns at the first falling edge where ENABLE is high (START cycle).
  task automatic wait_enable(output bit ok);
    int k;
    k = 0;
    while (ENABLE !== 1'b1 && k < 2 * PERIOD + 10) begin
      @(negedge clk);
      k++;
    end
    ok = (ENABLE === 1'b1);
    if (!ok) chk("enable_wait_bound", 0, 1);
    rise_cyc = cyc;
  endtask

  // Ranging model: raise DONE 'lat' cycles after START, report the outputs
  // seen two clocks after the capture cycle.
  task automatic meas(input int dv, input int lat, output bit gv, output int gavg,
                      output bit gnear, output bit gto);
    bit ok;
    gv = 0; gavg = 0; gnear = 0; gto = 1;
    wait_enable(ok);
    if (!ok) return;
    repeat (lat) @(negedge clk);
    d    = dv[7:0];
    DONE = 1'b1;
    @(negedge clk);
    chk("enable_drop_after_capture", ENABLE, 0);
    chk("valid_too_early", valid, 0);
    @(negedge clk);
    gv = valid; gavg = dist_avg; gnear = near; gto = timeout_err;
    @(negedge clk);
    chk("valid_one_cycle", valid, 0);
    DONE = 1'b0;
  endtask

  task automatic meas_check(input int dv, input int lat, input string tag);
    bit gv, gn, gt, ev, en;
    int ga, ea;
    meas(dv, lat, gv, ga, gn, gt);
    model_push(dv, ev, ea, en);
    chk({tag, "_valid"}, gv, ev);
    if (ev) begin
      chk({tag, "_avg"}, ga, ea);
      chk({tag, "_near"}, gn, en);
    end
    chk({tag, "_timeout_err"}, gt, 0);
  endtask

  // No DONE: ENABLE must drop and timeout_err rise TMO clocks after START.
  task automatic meas_timeout();
    bit ok;
    int k;
    wait_enable(ok);
    if (!ok) return;
    k = 0;
    while (ENABLE === 1'b1 && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, TMO);
    chk("timeout_err_set", timeout_err, 1);
  endtask

  initial begin
    #(950000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    bit gv, gn, gt, ok, seen;
    int ga;
    int rises[16];

    tbl[0]  = '{47, 0, 0, 0};  tbl[1]  = '{47, 0, 0, 0};
    tbl[2]  = '{47, 0, 0, 0};  tbl[3]  = '{47, 1, 47, 0};
    tbl[4]  = '{10, 1, 37, 0}; tbl[5]  = '{10, 1, 28, 0};
    tbl[6]  = '{10, 1, 19, 1}; tbl[7]  = '{10, 1, 10, 1};
    tbl[8]  = '{22, 1, 13, 1}; tbl[9]  = '{22, 1, 16, 1};
    tbl[10] = '{22, 1, 19, 1}; tbl[11] = '{22, 1, 22, 1};
    tbl[12] = '{30, 1, 24, 1}; tbl[13] = '{30, 1, 26, 0};
    tbl[14] = '{30, 1, 28, 0}; tbl[15] = '{30, 1, 30, 0};

    reset = 1'b1; run = 1'b0; DONE = 1'b0; d = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_enable", ENABLE, 0);
    chk("reset_dist_avg", dist_avg, 0);
    chk("reset_valid", valid, 0);
    chk("reset_near", near, 0);
    chk("reset_timeout_err", timeout_err, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_enable_low", ENABLE, 0);

    // Basic start, filter arithmetic and hysteresis.
    run = 1'b1;
    @(negedge clk);
    chk("enable_after_run", ENABLE, 1);
    for (int i = 0; i < 16; i++) begin
      bit ev, en;
      int ea;
      meas(tbl[i].d, 5 + i * 7, gv, ga, gn, gt);
      model_push(tbl[i].d, ev, ea, en);
      rises[i] = rise_cyc;
      chk("tbl_valid", gv, tbl[i].v);
      if (tbl[i].v) begin
        chk("tbl_avg", ga, tbl[i].avg);
        chk("tbl_near", gn, tbl[i].nr);
      end
    end
    for (int i = 1; i < 4; i++) chk("enable_period", rises[i] - rises[i-1], PERIOD);

    // Timeout: a stray d must not enter the buffer.
    d = 8'd200;
    meas_timeout();
    meas_check(30, 100, "after_timeout");

    // DONE rising on the timeout terminal cycle is accepted.
    meas_check(12, TMO - 1, "simultaneous");

    // DONE already high when the measurement starts is not an edge.
    DONE = 1'b1;
    wait_enable(ok);
    repeat (5) @(negedge clk);
    chk("held_done_ignored", ENABLE, 1);
    DONE = 1'b0;
    meas_check(40, 2, "retoggle");

    // Randomized measurements with occasional lost echoes.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        d = 8'($urandom_range(0, 255));
        meas_timeout();
      end else begin
        meas_check(int'($urandom_range(0, 45)), int'($urandom_range(1, TMO - 1)), "rand");
      end
    end

    // run dropped mid-WAIT: measurement completes, then no further START.
    wait_enable(ok);
    repeat (50) @(negedge clk);
    run = 1'b0;
    meas_check(33, 30, "run_drop");
    seen = 0;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      if (ENABLE !== 1'b0) seen = 1;
    end
    chk("no_start_after_run_drop", seen, 0);

    // Asynchronous reset mid-WAIT.
    run = 1'b1;
    wait_enable(ok);
    repeat (20) @(negedge clk);
    chk("pre_reset_enable", ENABLE, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_enable", ENABLE, 0);
    chk("async_reset_dist_avg", dist_avg, 0);
    chk("async_reset_near", near, 0);
    chk("async_reset_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      meas_check(int'($urandom_range(0, 45)), int'($urandom_range(1, TMO - 1)), "post_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
